// File: rtl/gated_counter_pkg.sv
// gated_counter_pkg: shared direction encodings and load clamping for the counter bank
package gated_counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic int clamp_load(int val, int m);
    return val >= m ? m - 1 : val;
  endfunction
endpackage

// File: rtl/gated_counter_bank_if.sv
// gated_counter_bank_if: control and status bus of the counter bank
interface gated_counter_bank_if #(
  parameter int N_CH = 4,
  parameter int WIDTH = 4
);
  logic en;
  logic [N_CH-1:0] ch_en;
  logic [N_CH-1:0] dir;
  logic [N_CH-1:0] load;
  logic [N_CH*WIDTH-1:0] load_val;
  logic [N_CH-1:0] clr_ovf;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0] tc;
  logic [N_CH-1:0] ovf;
  modport master(output en, ch_en, dir, load, load_val, clr_ovf, input count, tc, ovf);
  modport slave(input en, ch_en, dir, load, load_val, clr_ovf, output count, tc, ovf);
endinterface

// File: rtl/gated_counter_ch.sv
// gated_counter_ch: one modulo-MOD up/down counter with load, terminal-count pulse and sticky overflow
module gated_counter_ch
  import gated_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
  logic step;
  logic wrap;
  logic [WIDTH-1:0] nxt;
  // load beats step; wrap is detected explicitly so MOD==2**WIDTH still flags it
  always_comb begin
    step = en & ~load;
    wrap = step & (dir == DIR_UP ? count == TOP : count == '0);
    nxt = load ? WIDTH'(clamp_load(int'(load_val), MOD)) :
          !step ? count :
          wrap ? (dir == DIR_UP ? '0 : TOP) :
          dir == DIR_UP ? count + 1'b1 : count - 1'b1;
  end
  // registered count, one-cycle wrap pulse, sticky overflow where set beats clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else begin
      count <= nxt;
      tc <= wrap;
      ovf <= wrap | (ovf & ~clr_ovf);
    end
  end
endmodule

// File: rtl/gated_counter_bank.sv
// gated_counter_bank: N_CH independent counters, each gated by global AND channel enable
module gated_counter_bank #(
  parameter int N_CH = 4,
  parameter int WIDTH = 4,
  parameter int MOD = 10
) (
  input logic clk,
  input logic rst_n,
  gated_counter_bank_if.slave bus
);
  if (MOD < 2 || MOD > 2 ** WIDTH) begin : g_bad_mod
    $fatal(1, "gated_counter_bank: MOD %0d out of range for WIDTH %0d", MOD, WIDTH);
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    gated_counter_ch #(.WIDTH(WIDTH), .MOD(MOD)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(bus.en & bus.ch_en[i]),
      .dir(bus.dir[i]),
      .load(bus.load[i]),
      .load_val(bus.load_val[i*WIDTH +: WIDTH]),
      .clr_ovf(bus.clr_ovf[i]),
      .count(bus.count[i*WIDTH +: WIDTH]),
      .tc(bus.tc[i]),
      .ovf(bus.ovf[i])
    );
  end
endmodule

// File: tb/tb_gated_counter_bank.sv
// tb_gated_counter_bank: directed checks of the counter bank against hand-computed values
module tb_gated_counter_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  gated_counter_bank_if #(.N_CH(4), .WIDTH(4)) bus ();
  gated_counter_bank_if #(.N_CH(1), .WIDTH(2)) bus2 ();
  gated_counter_bank #(.N_CH(4), .WIDTH(4), .MOD(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  gated_counter_bank #(.N_CH(1), .WIDTH(2), .MOD(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus2.en = 1'b0;
    bus2.ch_en = '0;
    bus2.dir = '0;
    bus2.load = '0;
    bus2.load_val = '0;
    bus2.clr_ovf = '0;
    bus.en = 1'($urandom);
    bus.ch_en = 4'($urandom);
    bus.dir = 4'($urandom);
    bus.load = 4'($urandom);
    bus.load_val = 16'($urandom);
    bus.clr_ovf = 4'($urandom);
    tick();
    tick();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_tc", 32'(bus.tc), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_count2", 32'(bus2.count), 0);
    bus.ch_en = '0;
    bus.load = '0;
    bus.load_val = '0;
    bus.clr_ovf = '0;
    bus.en = 1'b1;
    bus.ch_en = 4'b0001;
    bus.dir = 4'hF;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("up_count0_%0d", k), 32'(bus.count[3:0]), k % 10);
      chk($sformatf("up_tc0_%0d", k), 32'(bus.tc[0]), k == 10);
      chk($sformatf("up_ovf0_%0d", k), 32'(bus.ovf[0]), k >= 10);
      chk($sformatf("up_others_%0d", k), 32'(bus.count[15:4]), 0);
    end
    bus.en = 1'b0;
    bus.ch_en = 4'hF;
    for (int k = 0; k < 3; k++) tick();
    chk("gate_off_count", 32'(bus.count), 32'h0002);
    bus.en = 1'b1;
    bus.ch_en = 4'h5;
    for (int k = 0; k < 3; k++) tick();
    chk("gate_on_count", 32'(bus.count), 32'h0305);
    chk("gate_on_tc", 32'(bus.tc), 0);
    bus.en = 1'b0;
    bus.ch_en = '0;
    bus.load = 4'b0010;
    bus.load_val = 16'h00F0;
    tick();
    chk("clamp_count1", 32'(bus.count[7:4]), 9);
    chk("clamp_tc", 32'(bus.tc), 0);
    bus.load_val = 16'h0000;
    tick();
    chk("load0_count1", 32'(bus.count[7:4]), 0);
    chk("load0_tc", 32'(bus.tc), 0);
    bus.load = '0;
    bus.en = 1'b1;
    bus.ch_en = 4'b0010;
    bus.dir = 4'b1101;
    tick();
    chk("down_wrap_count1", 32'(bus.count[7:4]), 9);
    chk("down_wrap_tc", 32'(bus.tc), 32'b0010);
    chk("down_wrap_ovf", 32'(bus.ovf), 32'b0011);
    bus.en = 1'b0;
    tick();
    chk("tc_one_cycle", 32'(bus.tc), 0);
    chk("hold_count", 32'(bus.count), 32'h0395);
    bus.en = 1'b1;
    bus.ch_en = 4'b0001;
    bus.dir = 4'hF;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_wrap_count0", 32'(bus.count[3:0]), 9);
    bus.clr_ovf = 4'b0001;
    tick();
    chk("conflict_count0", 32'(bus.count[3:0]), 0);
    chk("conflict_tc0", 32'(bus.tc[0]), 1);
    chk("conflict_ovf0", 32'(bus.ovf[0]), 1);
    tick();
    chk("clear_count0", 32'(bus.count[3:0]), 1);
    chk("clear_ovf", 32'(bus.ovf), 32'b0010);
    bus.clr_ovf = '0;
    bus.en = 1'b0;
    bus.load = 4'b1000;
    bus.load_val = 16'h9000;
    tick();
    chk("load3_count", 32'(bus.count), 32'h9391);
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.ch_en = 4'b1001;
    bus.load = 4'b0010;
    bus.load_val = 16'h0050;
    tick();
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_tc", 32'(bus.tc), 0);
    chk("midrst_ovf", 32'(bus.ovf), 0);
    rst_n = 1'b1;
    bus.load = '0;
    bus.ch_en = 4'b0001;
    tick();
    chk("resume_count", 32'(bus.count), 32'h0001);
    bus.en = 1'b0;
    bus2.en = 1'b1;
    bus2.ch_en = 1'b1;
    bus2.dir = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("pow2_count_%0d", k), 32'(bus2.count), k % 4);
      chk($sformatf("pow2_tc_%0d", k), 32'(bus2.tc), k == 4);
    end
    chk("pow2_ovf", 32'(bus2.ovf), 1);
    bus2.dir = 1'b0;
    tick();
    chk("pow2_down_count", 32'(bus2.count), 3);
    chk("pow2_down_tc", 32'(bus2.tc), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
